// File: rtl/ysyx_24100006_pkg.sv
// Shared types for the EXE->MEM pipeline register.
// Optional feature macro: YSYX_24100006_DEBUG_PC_EN adds a PC field to the payload.
package ysyx_24100006_pkg;

  // sram_read_write encodings
  localparam logic [1:0] SRW_NONE  = 2'b00;
  localparam logic [1:0] SRW_LOAD  = 2'b01;
  localparam logic [1:0] SRW_STORE = 2'b10;

  // Occupancy of the 2-entry skid buffer; also exported as a debug view.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Everything EXEU hands to MEMU in one transfer.
  typedef struct packed {
`ifdef YSYX_24100006_DEBUG_PC_EN
    logic [31:0] pc;
`endif
    logic [31:0] alu_result;
    logic [31:0] wdata_gpr;
    logic [31:0] wdata_csr;
    logic        irq;
    logic        gpr_write;
    logic        csr_write;
    logic        is_break;
    logic [3:0]  irq_no;
    logic [3:0]  gpr_write_addr;
    logic [11:0] csr_write_addr;
    logic [1:0]  gpr_write_rd;
    logic [1:0]  sram_read_write;
    logic [2:0]  mem_mask;
  } exe_mem_payload_t;

  localparam int EXE_MEM_PAYLOAD_W = $bits(exe_mem_payload_t);

endpackage

// File: rtl/ysyx_24100006_skid2.sv
// Generic 2-entry skid buffer. Both in_ready and out_valid come straight from
// flops, so downstream backpressure never reaches the upstream combinationally.
// Handshake: a side transfers on a rising clk edge where valid && ready are both
// high; valid may not depend on ready, and an offered item stays stable until taken.
module ysyx_24100006_skid2
  import ysyx_24100006_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [W-1:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [W-1:0] out_data,
  output skid_state_t state
);

  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = head;

  // Occupancy FSM with registered handshake outputs and slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_fire) begin
            head      <= in_data;
            state     <= SKID_ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            head <= in_data;
          end else if (out_fire) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else if (in_fire) begin
            // Head is stalled: park the in-flight item and close the input.
            skid     <= in_data;
            state    <= SKID_FULL;
            in_ready <= 1'b0;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            head     <= skid;
            state    <= SKID_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= SKID_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ysyx_24100006_exe_mem.sv
// EXE->MEM pipeline register built on a 2-entry skid buffer, plus MEM-stage
// forwarding / load-use information taken from the head entry.
// Optional feature macro: YSYX_24100006_DEBUG_PC_EN adds pc_M / pc_W.
module ysyx_24100006_exe_mem
  import ysyx_24100006_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_in_valid,
  output logic        exe_in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] wdata_gpr_M,
  input  logic [31:0] wdata_csr_M,
  input  logic        irq_M,
  input  logic        Gpr_Write_M,
  input  logic        Csr_Write_M,
  input  logic        is_break_i,
  input  logic [3:0]  irq_no_M,
  input  logic [3:0]  Gpr_Write_Addr_M,
  input  logic [11:0] Csr_Write_Addr_M,
  input  logic [1:0]  Gpr_Write_RD_M,
  input  logic [1:0]  sram_read_write_M,
  input  logic [2:0]  Mem_Mask_M,
`ifdef YSYX_24100006_DEBUG_PC_EN
  input  logic [31:0] pc_M,
  output logic [31:0] pc_W,
`endif
  output logic        mem_out_valid,
  input  logic        mem_out_ready,
  output logic [31:0] alu_result_W,
  output logic [31:0] wdata_gpr_W,
  output logic [31:0] wdata_csr_W,
  output logic        irq_W,
  output logic        Gpr_Write_W,
  output logic        Csr_Write_W,
  output logic        is_break_W,
  output logic [3:0]  irq_no_W,
  output logic [3:0]  Gpr_Write_Addr_W,
  output logic [11:0] Csr_Write_Addr_W,
  output logic [1:0]  Gpr_Write_RD_W,
  output logic [1:0]  sram_read_write_W,
  output logic [2:0]  Mem_Mask_W,
  output logic        mem_is_load,
  output logic        mem_fw_we,
  output logic [3:0]  mem_fw_addr,
  output logic [31:0] mem_fw_data
);

  exe_mem_payload_t in_pl;
  exe_mem_payload_t head_pl;
  skid_state_t      skid_state;
  logic             head_live;

  // Pack the EXE-side fields into one payload word.
  always_comb begin
    in_pl                 = '0;
`ifdef YSYX_24100006_DEBUG_PC_EN
    in_pl.pc              = pc_M;
`endif
    in_pl.alu_result      = alu_result;
    in_pl.wdata_gpr       = wdata_gpr_M;
    in_pl.wdata_csr       = wdata_csr_M;
    in_pl.irq             = irq_M;
    in_pl.gpr_write       = Gpr_Write_M;
    in_pl.csr_write       = Csr_Write_M;
    in_pl.is_break        = is_break_i;
    in_pl.irq_no          = irq_no_M;
    in_pl.gpr_write_addr  = Gpr_Write_Addr_M;
    in_pl.csr_write_addr  = Csr_Write_Addr_M;
    in_pl.gpr_write_rd    = Gpr_Write_RD_M;
    in_pl.sram_read_write = sram_read_write_M;
    in_pl.mem_mask        = Mem_Mask_M;
  end

  ysyx_24100006_skid2 #(
    .W(EXE_MEM_PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (exe_in_valid),
    .in_ready (exe_in_ready),
    .in_data  (in_pl),
    .out_valid(mem_out_valid),
    .out_ready(mem_out_ready),
    .out_data (head_pl),
    .state    (skid_state)
  );

  // Head occupancy straight from the buffer state; it matches mem_out_valid.
  assign head_live = (skid_state != SKID_EMPTY);

  // Unpack the head entry onto the MEM-side outputs.
  always_comb begin
`ifdef YSYX_24100006_DEBUG_PC_EN
    pc_W              = head_pl.pc;
`endif
    alu_result_W      = head_pl.alu_result;
    wdata_gpr_W       = head_pl.wdata_gpr;
    wdata_csr_W       = head_pl.wdata_csr;
    irq_W             = head_pl.irq;
    Gpr_Write_W       = head_pl.gpr_write;
    Csr_Write_W       = head_pl.csr_write;
    is_break_W        = head_pl.is_break;
    irq_no_W          = head_pl.irq_no;
    Gpr_Write_Addr_W  = head_pl.gpr_write_addr;
    Csr_Write_Addr_W  = head_pl.csr_write_addr;
    Gpr_Write_RD_W    = head_pl.gpr_write_rd;
    sram_read_write_W = head_pl.sram_read_write;
    Mem_Mask_W        = head_pl.mem_mask;
  end

  // Forwarding: an empty stage never reports a hazard.
  always_comb begin
    mem_is_load = head_live && (head_pl.sram_read_write == SRW_LOAD);
    mem_fw_we   = head_live && head_pl.gpr_write;
    mem_fw_addr = head_pl.gpr_write_addr;
    mem_fw_data = head_pl.wdata_gpr;
  end

endmodule

// File: doc/ysyx_24100006_exe_mem.md
# ysyx_24100006_exe_mem

Receiving end of the EXEU→EXE_MEM valid/ready handshake: a 2-entry skid buffer that registers the execute-stage payload and presents it to MEMU one cycle later. `exe_in_ready` is a pure flop output, so MEMU backpressure never forms a combinational path back into EXEU/IDU. The block also exports MEM-stage forwarding/load-use information from the head entry.

## Interface
- No parameters. Payload width comes from `EXE_MEM_PAYLOAD_W` in the package.

Ports:
- `clk` — input — 1 — clock.
- `reset` — input — 1 — asynchronous, active-low reset.
- `exe_in_valid` — input — 1 — EXEU offers a payload.
- `exe_in_ready` — output — 1 — buffer can accept; registered.
- `alu_result`, `wdata_gpr_M`, `wdata_csr_M` — input — 32 each — data payload.
- `irq_M`, `Gpr_Write_M`, `Csr_Write_M`, `is_break_i` — input — 1 each — control payload.
- `irq_no_M` — input — 4 — control payload.
- `Gpr_Write_Addr_M` — input — 4 — control payload.
- `Csr_Write_Addr_M` — input — 12 — control payload.
- `Gpr_Write_RD_M`, `sram_read_write_M` — input — 2 each — control payload.
- `Mem_Mask_M` — input — 3 — control payload.
- `mem_out_valid` — output — 1 — head entry valid toward MEMU.
- `mem_out_ready` — input — 1 — MEMU accepts the head.
- `*_W` — output — same widths — head-entry copy of each payload field, e.g. `alu_result_W`, `Mem_Mask_W`, `is_break_W`.
- `mem_is_load` — output — 1 — `mem_out_valid && sram_read_write_W == 2'b01`.
- `mem_fw_we` — output — 1 — `mem_out_valid && Gpr_Write_W`.
- `mem_fw_addr` — output — 4 — `Gpr_Write_Addr_W`.
- `mem_fw_data` — output — 32 — `wdata_gpr_W`.

## Operation
- Transfers: input transfer = `exe_in_valid && exe_in_ready`. Output transfer = `mem_out_valid && mem_out_ready`.
- Storage: two slots, HEAD (drives all `*_W` outputs) and SKID. State is a 2-bit count: EMPTY, ONE, FULL.
- EMPTY:
  - Input transfer → write HEAD → ONE.
- ONE:
  - Input and output transfer together → HEAD loads input, stays ONE.
  - Output transfer only → EMPTY.
  - Input transfer only → write SKID → FULL.
- FULL:
  - Input cannot transfer because ready is 0.
  - Output transfer → SKID moves to HEAD → ONE.
- Handshake outputs:
  - `exe_in_ready` = 1 in EMPTY or ONE, 0 in FULL; driven from a flop updated with the next state.
  - `mem_out_valid` = 1 in ONE or FULL.
- Ordering is strictly FIFO. No payload is dropped or duplicated.
- The payload is held stable while `mem_out_valid && !mem_out_ready`.
- No flush input: EXE-stage redirects only kill younger instructions, so entries here are never squashed.

## Timing
- Latency is 1 cycle: a payload accepted at edge N appears on `*_W` with `mem_out_valid = 1` after edge N.
- Throughput is 1 per cycle while `mem_out_ready` is held high. The SKID slot is used only when `mem_out_ready` drops.
- `exe_in_ready` deasserts the cycle after FULL is entered. The SKID slot absorbs the one in-flight transfer.
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - State goes to EMPTY.
  - `mem_out_valid = 0`, `exe_in_ready = 1`.
  - All `*_W` outputs and forwarding outputs = 0.
- Reset asserted mid-operation discards both entries immediately.
- While `mem_out_valid = 0`, forwarding outputs report no hazard: `mem_is_load = 0`, `mem_fw_we = 0`.

## Configuration
- `YSYX_24100006_DEBUG_PC_EN` defined:
  - Adds input `pc_M[31:0]` and output `pc_W[31:0]`.
  - The PC travels through both slots exactly like the other payload fields and resets to 0.
- Macro undefined: the ports and storage do not exist. Behaviour is otherwise identical.

## Structure
- `ysyx_24100006_pkg` holds:
  - `EXE_MEM_PAYLOAD_W`.
  - Encodings for `sram_read_write`: `SRW_NONE = 2'b00`, `SRW_LOAD = 2'b01`, `SRW_STORE = 2'b10`.
  - A packed struct `exe_mem_payload_t` that concatenates the payload fields; the PC field is included only under the macro.
- Sub-module `ysyx_24100006_skid2`:
  - Generic width-parameterised 2-entry skid buffer with valid/ready on both sides.
  - This block instantiates it once. Packing and unpacking of the struct, plus the forwarding logic, stay in the top module.

## Test plan
- Reset release with `exe_in_valid = 0` → `exe_in_ready = 1`, `mem_out_valid = 0`, `alu_result_W = 0`.
- Streaming: `mem_out_ready = 1` held; `alu_result` values 1, 2, 3 offered on consecutive cycles → `alu_result_W` shows 1, 2, 3 one cycle later with no bubbles.
- Stall fill:
  - Two payloads are accepted (`0xA`, `0xB`) while `mem_out_ready = 0` → FULL, and `exe_in_ready = 0` on the next cycle.
  - `mem_out_ready` then raised → `0xA`, then `0xB`, with `exe_in_ready` returning to 1 after the first pop.
- Load forwarding: payload with `sram_read_write_M = 01`, `Gpr_Write_Addr_M = 5`, `Gpr_Write_M = 1`, `wdata_gpr_M = 0x1234` → `mem_is_load = 1`, `mem_fw_we = 1`, `mem_fw_addr = 5`, `mem_fw_data = 0x1234`.
- Reset while FULL → all outputs 0 and `exe_in_ready = 1` immediately; the next accepted payload is the first one seen on `*_W`.
- Under `YSYX_24100006_DEBUG_PC_EN`: PCs `0x8000_0000` and `0x8000_0004` are pushed through a stall → `pc_W` stays aligned with `alu_result_W` for each entry.
